mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge.sv | 96 +++++++++
 tb/tb_mmio_bridge.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes CPU loads/stores into an I/O window and sequences single-cycle strobes to the I/O controller.
// Optional WAIT-state timeout with sticky io_error is enabled by defining MMIO_TIMEOUT_EN.
module mmio_bridge #(
  parameter logic [63:0] IO_BASE        = 64'h0000_0000_1000_0000,
  parameter logic [63:0] IO_MASK        = 64'hFFFF_FFFF_FFFF_FFF8,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] cpu_addr,
  input  logic [63:0] cpu_wdata,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  output logic [63:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        io_hit,
  output logic [63:0] io_data_in,
  input  logic [63:0] io_data_out,
  output logic        io_read,
  output logic        io_write,
  input  logic        io_ready,
  output logic        io_error
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic op_wr_q, op_wr_d, rd_q, rd_d, wr_q, wr_d, timeout;
  logic [63:0] rdata_q, rdata_d, din_q, din_d;
  assign io_hit     = ((cpu_addr & IO_MASK) == IO_BASE) && (cpu_mem_read || cpu_mem_write);
  assign cpu_stall  = (state_q == REQ) || (state_q == WAIT) || (state_q == IDLE && io_hit);
  assign cpu_rdata  = rdata_q;
  assign io_data_in = din_q;
  assign io_read    = rd_q;
  assign io_write   = wr_q;
`ifdef MMIO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  assign timeout  = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign io_error = err_q;
  always_comb begin
    cnt_d = (state_q == WAIT && !io_ready && !timeout) ? cnt_q + 1'b1 : '0;
    err_d = err_q || (state_q == WAIT && !io_ready && timeout);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  assign timeout  = 1'b0;
  assign io_error = 1'b0;
`endif
  // Strobes are registered on the IDLE->REQ transition so they are high exactly while in REQ.
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    rdata_d = rdata_q;
    din_d   = din_q;
    case (state_q)
      IDLE: if (io_hit) begin
        state_d = REQ;
        din_d   = cpu_wdata;
        op_wr_d = cpu_mem_write;
        rd_d    = !cpu_mem_write;
        wr_d    = cpu_mem_write;
      end
      REQ:  state_d = WAIT;
      WAIT: if (io_ready || timeout) begin
        state_d = DONE;
        rdata_d = op_wr_q ? rdata_q : io_ready ? io_data_out : 64'hDEAD_DEAD_DEAD_DEAD;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
    end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: randomized MMIO accesses checked against a transaction-level model of stall length, strobes and data.
module tb_mmio_bridge;
  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
  localparam logic [63:0] MASK = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam int          TO   = 16;
`ifdef MMIO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0, io_data_out = '0;
  logic cpu_mem_read = 1'b0, cpu_mem_write = 1'b0, io_ready = 1'b0;
  logic [63:0] cpu_rdata, io_data_in;
  logic cpu_stall, io_hit, io_read, io_write, io_error;
  int checks = 0, errors = 0;
  logic [63:0] m_rdata = '0, m_din = '0;
  logic m_err = 1'b0;

  mmio_bridge dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .io_hit(io_hit), .io_data_in(io_data_in), .io_data_out(io_data_out),
    .io_read(io_read), .io_write(io_write), .io_ready(io_ready), .io_error(io_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU access held until the stall drops; the controller answers lat cycles after its strobe.
  task automatic access(input logic [63:0] a, input logic [63:0] w, input logic rd, input logic wr,
                        input int lat, input logic [63:0] rv);
    bit hit, timed_out;
    int n_stall, n_rd, n_wr, cyc, sc;
    n_stall = 0; n_rd = 0; n_wr = 0; cyc = 0; sc = -1;
    hit = ((a & MASK) == BASE) && (rd || wr);
    timed_out = hit && TO_EN && lat > TO;
    @(negedge clk);
    cpu_addr = a; cpu_wdata = w; cpu_mem_read = rd; cpu_mem_write = wr; io_data_out = rv;
    io_ready = 1'b0;
    #1 chk("io_hit", {63'd0, io_hit}, {63'd0, hit});
    forever begin
      io_ready = sc >= 0 && cyc == sc + lat;
      #1;
      if (!cpu_stall) break;
      n_stall++;
      if (io_read) begin n_rd++; sc = cyc; end
      if (io_write) begin n_wr++; sc = cyc; end
      cyc++;
      if (cyc > 60) begin
        chk("stall_bound", 64'd1, 64'd0);
        break;
      end
      @(negedge clk);
    end
    chk("stall_cycles", 64'(n_stall), !hit ? 64'd0 : timed_out ? 64'(2 + TO) : 64'(2 + lat));
    chk("read_pulses", 64'(n_rd), {63'd0, hit && !wr});
    chk("write_pulses", 64'(n_wr), {63'd0, hit && wr});
    if (hit) begin
      m_din = w;
      if (!wr) m_rdata = timed_out ? 64'hDEAD_DEAD_DEAD_DEAD : rv;
      if (timed_out) m_err = 1'b1;
    end
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("io_data_in", io_data_in, m_din);
    chk("io_error", {63'd0, io_error}, {63'd0, m_err});
    chk("done_strobes", {62'd0, io_read, io_write}, 64'd0);
    @(negedge clk);
    cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
    io_ready = 1'($urandom_range(0, 1));
    #1 chk("idle_after", {61'd0, cpu_stall, io_read, io_write}, 64'd0);
  endtask

  // Reset asserted mid-access (stage 0: REQ, stage 1: WAIT) must abort it cleanly.
  task automatic reset_abort(input int stage);
    @(negedge clk);
    cpu_addr = BASE; cpu_wdata = 64'h55; cpu_mem_read = 1'b1; cpu_mem_write = 1'b0;
    io_ready = 1'b0; io_data_out = 64'h77;
    repeat (stage + 1) @(negedge clk);
    #1 chk("pre_rst_rd", {63'd0, io_read}, {63'd0, stage == 0});
    reset = 1'b1;
    #1;
    chk("rst_strobes", {62'd0, io_read, io_write}, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall}, 64'd1);
    chk("rst_rdata", cpu_rdata, 64'd0);
    chk("rst_din", io_data_in, 64'd0);
    m_rdata = '0; m_din = '0; m_err = 1'b0;
    cpu_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1 chk("post_rst", {61'd0, cpu_stall, io_read, io_write}, 64'd0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdata", cpu_rdata, 64'd0);
    chk("reset_din", io_data_in, 64'd0);
    chk("reset_outs", {60'd0, io_read, io_write, io_error, cpu_stall}, 64'd0);
    reset = 1'b0;
    access(BASE, 64'h1234, 1'b0, 1'b1, 1, 64'h9999);
    access(BASE, 64'h0, 1'b1, 1'b0, 1, 64'hABCD);
    access(64'h2000_0000, 64'h0, 1'b1, 1'b0, 1, 64'h1111);
    access(BASE, 64'h4321, 1'b1, 1'b1, 1, 64'h2222);
    access(BASE + 64'd7, 64'h0, 1'b1, 1'b0, 3, 64'hCAFE);
    access(BASE + 64'd8, 64'h0, 1'b1, 1'b0, 1, 64'hBEEF);
    reset_abort(0);
    reset_abort(1);
    for (int i = 0; i < 40; i++) begin
      logic [63:0] a;
      logic [1:0] op;
      int sel, lat;
      sel = $urandom_range(0, 3);
      a = sel < 2 ? BASE | 64'($urandom_range(0, 7))
        : sel == 2 ? BASE ^ (64'h8 << $urandom_range(0, 59)) : {$urandom, $urandom};
      op = 2'($urandom_range(0, 3));
      lat = $urandom_range(0, 3) == 0 ? $urandom_range(2, 4) : 1;
      access(a, {$urandom, $urandom}, op[0], op[1], lat, {$urandom, $urandom});
    end
    if (TO_EN) begin
      access(BASE, 64'h0, 1'b1, 1'b0, 1000, 64'h3333);
      access(BASE, 64'h5A5A, 1'b0, 1'b1, 1, 64'h0);
      access(BASE, 64'h0, 1'b1, 1'b0, 2, 64'h4444);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
